regfile_dump_reader: RTL and testbench
======================================

Name: regfile_dump_reader

Overview:
- Read-side companion to the register file: a sequencer that, on command, walks every architectural register through the two combinational read ports (A1/RD1, A2/RD2).
- Streams each register's value, tagged with its index, out over a valid/ready interface.
- Used by debug/trace logic and by benches to snapshot the register file without disturbing the write port.

Parameters:
- DATA_WIDTH, 32, register data width
- ADDR_WIDTH, 5, register index width
- REG_COUNT, 32, number of registers dumped; must be even and at most 2**ADDR_WIDTH

Ports:
- CLK  input  1  clock; all state changes on rising edge
- RST_N  input  1  asynchronous active-low reset
- START  input  1  begin a dump; sampled only in IDLE
- ABORT  input  1  synchronous cancel; returns to IDLE next edge
- BUSY  output  1  high in any state other than IDLE
- DONE  output  1  one-cycle pulse after the last beat is accepted
- A1  output  ADDR_WIDTH  read address, port 1 (even index)
- A2  output  ADDR_WIDTH  read address, port 2 (odd index)
- RD1  input  DATA_WIDTH  register file read data, port 1 (combinational from A1)
- RD2  input  DATA_WIDTH  register file read data, port 2 (combinational from A2)
- OUT_VALID  output  1  output beat valid
- OUT_READY  input  1  downstream accepts beat
- OUT_DATA  output  DATA_WIDTH  register value
- OUT_ADDR  output  ADDR_WIDTH  register index of OUT_DATA

Behaviour:
- Reset (RST_N low, asynchronous):
  - state=IDLE, idx=0, buffers=0.
  - BUSY=0, DONE=0, OUT_VALID=0, OUT_DATA=0, OUT_ADDR=0, A1=0, A2=0.
- State machine and transitions:
  - IDLE: START=1 at an edge -> READ with idx=0.
  - READ (1 cycle): drive A1=idx, A2=idx+1. At the edge, capture RD1 into buf_lo and RD2 into buf_hi -> SEND_LO.
  - SEND_LO: OUT_VALID=1, OUT_DATA=buf_lo, OUT_ADDR=idx. On OUT_VALID&OUT_READY -> SEND_HI.
  - SEND_HI: OUT_VALID=1, OUT_DATA=buf_hi, OUT_ADDR=idx+1. On handshake:
    - if idx==REG_COUNT-2 -> DONE_ST;
    - else idx+=2 -> READ.
  - DONE_ST (1 cycle): DONE=1, BUSY=1, OUT_VALID=0 -> IDLE.
- Address outputs:
  - A1/A2 are registered from idx and remain stable in READ, SEND_LO and SEND_HI.
  - In IDLE and DONE_ST, A1=A2=0.
- Valid/ready rules:
  - OUT_DATA and OUT_ADDR are stable while OUT_VALID=1 and OUT_READY=0.
  - OUT_VALID never depends combinationally on OUT_READY.
  - Exactly REG_COUNT beats per completed dump, in index order 0..REG_COUNT-1.
- Snapshot semantics:
  - A register's value is the one present on RD at the READ edge for its pair.
  - Writes landing after that edge are not reflected in that pair's beats.
- Register 0 is forwarded as read; no forcing to zero in this block.
- Latency, START edge to first OUT_VALID: 2 cycles (READ cycle, then SEND_LO).
- Throughput with OUT_READY held high: 3 cycles per pair, so REG_COUNT*3/2 cycles from READ to the last handshake, plus 1 cycle for DONE_ST. For the default parameters this is 48 cycles plus 1.
- Boundary conditions:
  - START while BUSY: ignored.
  - START on the same edge DONE_ST exits: ignored. A new dump needs START in IDLE.
  - ABORT in any non-IDLE state: next edge goes to IDLE, OUT_VALID drops (the only permitted valid withdrawal without a handshake), no DONE pulse, idx=0.
  - ABORT and START together in IDLE: ABORT wins, stay IDLE.
  - ABORT on the same edge as the final handshake: ABORT wins, no DONE.
  - Reset mid-dump: immediate return to reset values; no DONE pulse.
  - idx arithmetic is ADDR_WIDTH wide. idx+1 never exceeds REG_COUNT-1, so there is no wrap.

Test Plan:
- Reg file preloaded reg[i]=i+10, OUT_READY=1, pulse START -> 32 beats (OUT_ADDR, OUT_DATA) = (0,10)..(31,41) in order; DONE pulse 49 cycles after the START edge; BUSY drops with DONE_ST exit.
- Same preload, OUT_READY toggled 1-0-1-0 -> identical 32-beat sequence; OUT_DATA and OUT_ADDR held stable during every stall; no duplicates, no drops.
- Write reg[5]=0xDEADBEEF at the edge right after the READ capture for pair (4,5) -> beat 5 shows 15, not 0xDEADBEEF. A second dump shows 0xDEADBEEF.
- ABORT asserted while OUT_ADDR=7 is stalled -> next cycle BUSY=0, OUT_VALID=0, no DONE. A subsequent START yields a full dump beginning at OUT_ADDR=0.
- START pulsed repeatedly during a dump -> ignored; exactly one DONE and 32 beats.
- RST_N driven low asynchronously mid-cycle during SEND_HI -> outputs return to reset values immediately; after release, IDLE holds until START.

Source files
------------

// File: rtl/regfile_dump_reader_if.sv
// Bundle of the register-file read ports and the outgoing valid/ready beat stream.
// master = dump reader, slave = register file plus downstream consumer.
interface regfile_dump_reader_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
);
   logic [ADDR_WIDTH-1:0] A1;
   logic [ADDR_WIDTH-1:0] A2;
   logic [DATA_WIDTH-1:0] RD1;
   logic [DATA_WIDTH-1:0] RD2;
   // Beat transfers on a rising edge with OUT_VALID & OUT_READY; once raised,
   // OUT_VALID/OUT_DATA/OUT_ADDR hold until that handshake (ABORT/reset excepted),
   // and OUT_VALID never depends on OUT_READY.
   logic                  OUT_VALID;
   logic                  OUT_READY;
   logic [DATA_WIDTH-1:0] OUT_DATA;
   logic [ADDR_WIDTH-1:0] OUT_ADDR;

   modport master (
      output A1, A2, OUT_VALID, OUT_DATA, OUT_ADDR,
      input  RD1, RD2, OUT_READY
   );

   modport slave (
      input  A1, A2, OUT_VALID, OUT_DATA, OUT_ADDR,
      output RD1, RD2, OUT_READY
   );
endinterface

// File: rtl/regfile_dump_reader.sv
// Walks every register through the two read ports a pair at a time and streams
// (index, value) beats out over valid/ready; a dump is a consistent per-pair snapshot.
module regfile_dump_reader #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int REG_COUNT  = 32
) (
   input  logic                   CLK,
   input  logic                   RST_N,
   input  logic                   START,
   input  logic                   ABORT,
   output logic                   BUSY,
   output logic                   DONE,
   output logic [2:0]             DBG_STATE,
   regfile_dump_reader_if.master  bus
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_READ    = 3'd1,
      S_SEND_LO = 3'd2,
      S_SEND_HI = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(REG_COUNT - 2);
   localparam logic [ADDR_WIDTH-1:0] ONE      = ADDR_WIDTH'(1);
   localparam logic [ADDR_WIDTH-1:0] TWO      = ADDR_WIDTH'(2);

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] idx_q, idx_d;
   logic [ADDR_WIDTH-1:0] a1_q, a1_d;
   logic [ADDR_WIDTH-1:0] a2_q, a2_d;
   logic [DATA_WIDTH-1:0] buf_lo_q, buf_lo_d;
   logic [DATA_WIDTH-1:0] buf_hi_q, buf_hi_d;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q  <= S_IDLE;
         idx_q    <= '0;
         a1_q     <= '0;
         a2_q     <= '0;
         buf_lo_q <= '0;
         buf_hi_q <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         a1_q     <= a1_d;
         a2_q     <= a2_d;
         buf_lo_q <= buf_lo_d;
         buf_hi_q <= buf_hi_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      buf_lo_d = buf_lo_q;
      buf_hi_d = buf_hi_q;
      if (ABORT && state_q != S_IDLE) begin
         state_d = S_IDLE;
         idx_d   = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (START && !ABORT) begin
                  state_d = S_READ;
                  idx_d   = '0;
               end
            end
            S_READ: begin
               // The pair's snapshot point: whatever RD shows at this edge.
               buf_lo_d = bus.RD1;
               buf_hi_d = bus.RD2;
               state_d  = S_SEND_LO;
            end
            S_SEND_LO: begin
               if (bus.OUT_READY) state_d = S_SEND_HI;
            end
            S_SEND_HI: begin
               if (bus.OUT_READY) begin
                  if (idx_q == LAST_IDX) begin
                     state_d = S_DONE;
                     idx_d   = '0;
                  end else begin
                     state_d = S_READ;
                     idx_d   = idx_q + TWO;
                  end
               end
            end
            S_DONE:  state_d = S_IDLE;
            default: begin
               state_d = S_IDLE;
               idx_d   = '0;
            end
         endcase
      end
   end

   // Addresses are registered off the next index so they stay steady for the whole pair.
   always_comb begin
      a1_d = '0;
      a2_d = '0;
      if (state_d == S_READ || state_d == S_SEND_LO || state_d == S_SEND_HI) begin
         a1_d = idx_d;
         a2_d = idx_d + ONE;
      end
   end

   always_comb begin
      BUSY         = (state_q != S_IDLE);
      DONE         = (state_q == S_DONE);
      bus.OUT_VALID = 1'b0;
      bus.OUT_DATA  = '0;
      bus.OUT_ADDR  = '0;
      case (state_q)
         S_SEND_LO: begin
            bus.OUT_VALID = 1'b1;
            bus.OUT_DATA  = buf_lo_q;
            bus.OUT_ADDR  = idx_q;
         end
         S_SEND_HI: begin
            bus.OUT_VALID = 1'b1;
            bus.OUT_DATA  = buf_hi_q;
            bus.OUT_ADDR  = idx_q + ONE;
         end
         default: ;
      endcase
   end

   assign bus.A1    = a1_q;
   assign bus.A2    = a2_q;
   assign DBG_STATE = state_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Bench for regfile_dump_reader: behavioural register file, randomized back-pressure,
// per-scenario tasks checking beat order, snapshot values, stalls, ABORT and reset.
module tb_regfile_dump_reader;
   localparam int DW = 32;
   localparam int AW = 5;
   localparam int RC = 32;

   logic CLK, RST_N, START, ABORT, BUSY, DONE;
   logic [2:0] DBG_STATE;
   regfile_dump_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) rf ();

   regfile_dump_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REG_COUNT(RC)) dut (
      .CLK(CLK), .RST_N(RST_N), .START(START), .ABORT(ABORT),
      .BUSY(BUSY), .DONE(DONE), .DBG_STATE(DBG_STATE), .bus(rf)
   );

   int checks = 0;
   int failures = 0;

   logic [DW-1:0] regs [RC];
   assign rf.RD1 = regs[rf.A1];
   assign rf.RD2 = regs[rf.A2];

   // clock / reset
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // ready driver: 0 always high, 1 toggle, 2 random, 3 stall on stall_addr
   int ready_mode = 0;
   logic [AW-1:0] stall_addr = '0;
   initial begin
      rf.OUT_READY = 1'b1;
      forever begin
         @(posedge CLK); #1;
         case (ready_mode)
            0: rf.OUT_READY = 1'b1;
            1: rf.OUT_READY = ~rf.OUT_READY;
            2: rf.OUT_READY = 1'($urandom_range(0, 1));
            default: rf.OUT_READY = !(rf.OUT_VALID && rf.OUT_ADDR == stall_addr);
         endcase
      end
   end

   // monitor: records accepted beats, DONE pulses and stall-stability violations
   logic [AW-1:0] got_addr_q[$];
   logic [DW-1:0] got_data_q[$];
   int done_count = 0;
   int stall_viol = 0;
   bit prev_stall = 0;
   logic [DW-1:0] prev_data;
   logic [AW-1:0] prev_addr;
   initial begin
      forever begin
         @(negedge CLK);
         if (!RST_N) begin
            prev_stall = 0;
         end else begin
            if (prev_stall && BUSY &&
                !(rf.OUT_VALID && rf.OUT_DATA == prev_data && rf.OUT_ADDR == prev_addr))
               stall_viol++;
            if (rf.OUT_VALID && rf.OUT_READY) begin
               got_addr_q.push_back(rf.OUT_ADDR);
               got_data_q.push_back(rf.OUT_DATA);
            end
            if (DONE) done_count++;
            prev_stall = rf.OUT_VALID && !rf.OUT_READY;
            prev_data  = rf.OUT_DATA;
            prev_addr  = rf.OUT_ADDR;
         end
      end
   end

   // driver: one dump; optional mid-dump write, START spam, START on the DONE_ST exit edge
   task automatic do_dump(input int wr_cycle, input int wr_addr, input logic [DW-1:0] wr_val,
                          input bit start_spam, input bit start_on_exit,
                          output int done_cyc, output logic busy_after);
      int n;
      got_addr_q.delete();
      got_data_q.delete();
      done_count = 0;
      stall_viol = 0;
      @(negedge CLK); #1;
      START = 1'b1;
      @(posedge CLK); #1;
      START = 1'b0;
      n = 0;
      done_cyc = -1;
      while (n < 3000 && done_cyc < 0) begin
         @(negedge CLK); #1;
         n++;
         if (n == wr_cycle) regs[wr_addr] = wr_val;
         if (DONE) done_cyc = n;
         else START = start_spam ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      START = start_on_exit;
      @(posedge CLK); #1;
      START = 1'b0;
      @(negedge CLK); #1;
      busy_after = BUSY;
   endtask

   task automatic test_reset();
      RST_N = 1'b0;
      #1;
      checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", BUSY); end
      checks++; if (DONE !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", DONE); end
      checks++; if (rf.OUT_VALID !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", rf.OUT_VALID); end
      checks++; if (rf.OUT_DATA !== '0 || rf.OUT_ADDR !== '0) begin failures++;
         $display("FAIL reset_out got=%h/%0d exp=0/0", rf.OUT_DATA, rf.OUT_ADDR); end
      checks++; if (rf.A1 !== '0 || rf.A2 !== '0) begin failures++;
         $display("FAIL reset_addr got=%0d/%0d exp=0/0", rf.A1, rf.A2); end
      @(negedge CLK); #1;
      RST_N = 1'b1;
      repeat (3) @(negedge CLK);
      #1;
      checks++; if (BUSY !== 1'b0 || rf.OUT_VALID !== 1'b0) begin failures++;
         $display("FAIL idle_after_reset busy=%b valid=%b exp=0/0", BUSY, rf.OUT_VALID); end
   endtask

   task automatic test_full_dump();
      int dc;
      logic ba;
      for (int i = 0; i < RC; i++) regs[i] = DW'(i + 10);
      ready_mode = 0;
      do_dump(0, 0, '0, 0, 0, dc, ba);
      checks++; if (dc !== 49) begin failures++; $display("FAIL full_done_cycle got=%0d exp=49", dc); end
      checks++; if (ba !== 1'b0) begin failures++; $display("FAIL full_busy_after got=%b exp=0", ba); end
      checks++; if (got_addr_q.size() !== RC) begin failures++;
         $display("FAIL full_beat_count got=%0d exp=%0d", got_addr_q.size(), RC); end
      for (int i = 0; i < RC && i < got_addr_q.size(); i++) begin
         checks++;
         if (got_addr_q[i] !== AW'(i) || got_data_q[i] !== DW'(i + 10)) begin failures++;
            $display("FAIL full_beat%0d got=(%0d,%h) exp=(%0d,%h)", i, got_addr_q[i], got_data_q[i], i, i + 10); end
      end
   endtask

   task automatic test_backpressure();
      int dc;
      logic ba;
      for (int i = 0; i < RC; i++) regs[i] = DW'(i + 10);
      ready_mode = 1;
      do_dump(0, 0, '0, 0, 1, dc, ba);
      ready_mode = 0;
      checks++; if (stall_viol !== 0) begin failures++; $display("FAIL bp_stall_stable got=%0d exp=0", stall_viol); end
      checks++; if (done_count !== 1) begin failures++; $display("FAIL bp_done_count got=%0d exp=1", done_count); end
      checks++; if (ba !== 1'b0) begin failures++; $display("FAIL bp_start_on_exit busy got=%b exp=0", ba); end
      checks++; if (got_addr_q.size() !== RC) begin failures++;
         $display("FAIL bp_beat_count got=%0d exp=%0d", got_addr_q.size(), RC); end
      for (int i = 0; i < RC && i < got_addr_q.size(); i++) begin
         checks++;
         if (got_addr_q[i] !== AW'(i) || got_data_q[i] !== DW'(i + 10)) begin failures++;
            $display("FAIL bp_beat%0d got=(%0d,%h) exp=(%0d,%h)", i, got_addr_q[i], got_data_q[i], i, i + 10); end
      end
   endtask

   task automatic test_random_traffic();
      int dc;
      logic ba;
      logic [DW-1:0] exp_q[$];
      for (int it = 0; it < 3; it++) begin
         exp_q.delete();
         for (int i = 0; i < RC; i++) begin
            regs[i] = $urandom;
            exp_q.push_back(regs[i]);
         end
         ready_mode = 2;
         do_dump(0, 0, '0, 1, 0, dc, ba);
         ready_mode = 0;
         checks++; if (dc < 49 || done_count !== 1 || stall_viol !== 0) begin failures++;
            $display("FAIL rand%0d_ctrl done_cyc=%0d dones=%0d viol=%0d exp>=49/1/0", it, dc, done_count, stall_viol); end
         checks++; if (got_addr_q.size() !== RC) begin failures++;
            $display("FAIL rand%0d_beat_count got=%0d exp=%0d", it, got_addr_q.size(), RC); end
         for (int i = 0; i < RC && i < got_addr_q.size(); i++) begin
            checks++;
            if (got_addr_q[i] !== AW'(i) || got_data_q[i] !== exp_q[i]) begin failures++;
               $display("FAIL rand%0d_beat%0d got=(%0d,%h) exp=(%0d,%h)", it, i, got_addr_q[i], got_data_q[i], i, exp_q[i]); end
         end
      end
   endtask

   // A register's beat reflects its value in the READ cycle of its pair: cycle 3*(r/2)+1.
   task automatic test_snapshot();
      int dc;
      logic ba;
      logic [DW-1:0] exp_q[$];
      int wr_cyc;
      for (int trial = 0; trial < 2; trial++) begin
         for (int i = 0; i < RC; i++) regs[i] = DW'(i + 10);
         wr_cyc = (trial == 0) ? 8 : 7;
         exp_q.delete();
         for (int r = 0; r < RC; r++)
            exp_q.push_back((r == 5 && wr_cyc <= 3 * (r / 2) + 1) ? 32'hDEADBEEF : DW'(r + 10));
         ready_mode = 0;
         do_dump(wr_cyc, 5, 32'hDEADBEEF, 0, 0, dc, ba);
         checks++; if (got_data_q.size() != RC || got_data_q[5] !== exp_q[5] || got_data_q[4] !== exp_q[4]) begin failures++;
            $display("FAIL snap%0d_beat5 got=%h exp=%h", trial, got_data_q.size() > 5 ? got_data_q[5] : 'x, exp_q[5]); end
         do_dump(0, 0, '0, 0, 0, dc, ba);
         checks++; if (got_data_q.size() != RC || got_data_q[5] !== 32'hDEADBEEF) begin failures++;
            $display("FAIL snap%0d_second_dump got=%h exp=deadbeef", trial, got_data_q.size() > 5 ? got_data_q[5] : 'x); end
      end
   endtask

   task automatic test_abort();
      int n;
      int dc;
      logic ba;
      for (int i = 0; i < RC; i++) regs[i] = DW'(i + 10);
      got_addr_q.delete(); got_data_q.delete();
      done_count = 0; stall_viol = 0;
      stall_addr = AW'(7);
      ready_mode = 3;
      @(negedge CLK); #1; START = 1'b1;
      @(posedge CLK); #1; START = 1'b0;
      n = 0;
      while (n < 200 && !(rf.OUT_VALID && rf.OUT_ADDR == AW'(7))) begin @(negedge CLK); #1; n++; end
      checks++; if (n >= 200) begin failures++; $display("FAIL abort_reach_addr7 got=timeout exp=addr7"); end
      repeat (3) @(negedge CLK);
      #1;
      checks++; if (rf.OUT_VALID !== 1'b1 || rf.OUT_ADDR !== AW'(7) || rf.OUT_DATA !== DW'(17) || stall_viol !== 0) begin failures++;
         $display("FAIL abort_stall_hold got=%b/%0d/%h exp=1/7/11", rf.OUT_VALID, rf.OUT_ADDR, rf.OUT_DATA); end
      ABORT = 1'b1;
      @(posedge CLK); #1; ABORT = 1'b0;
      ready_mode = 0;
      @(negedge CLK); #1;
      checks++; if (BUSY !== 1'b0 || rf.OUT_VALID !== 1'b0 || rf.A1 !== '0) begin failures++;
         $display("FAIL abort_idle busy=%b valid=%b a1=%0d exp=0/0/0", BUSY, rf.OUT_VALID, rf.A1); end
      checks++; if (got_addr_q.size() !== 7) begin failures++; $display("FAIL abort_beats got=%0d exp=7", got_addr_q.size()); end
      repeat (5) @(negedge CLK);
      #1;
      checks++; if (done_count !== 0) begin failures++; $display("FAIL abort_no_done got=%0d exp=0", done_count); end
      // ABORT with START in IDLE
      START = 1'b1; ABORT = 1'b1;
      @(posedge CLK); #1; START = 1'b0; ABORT = 1'b0;
      @(negedge CLK); #1;
      checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL abort_start_idle busy got=%b exp=0", BUSY); end
      do_dump(0, 0, '0, 0, 0, dc, ba);
      checks++; if (got_addr_q.size() !== RC || got_addr_q[0] !== '0 || got_addr_q[RC-1] !== AW'(RC - 1) || dc !== 49) begin failures++;
         $display("FAIL abort_redump beats=%0d done_cyc=%0d exp=%0d/49", got_addr_q.size(), dc, RC); end
   endtask

   task automatic test_abort_final();
      int n;
      ready_mode = 0;
      done_count = 0;
      @(negedge CLK); #1; START = 1'b1;
      @(posedge CLK); #1; START = 1'b0;
      n = 0;
      while (n < 48) begin @(negedge CLK); #1; n++; end
      checks++; if (rf.OUT_VALID !== 1'b1 || rf.OUT_ADDR !== AW'(RC - 1)) begin failures++;
         $display("FAIL abortfin_last_beat got=%b/%0d exp=1/%0d", rf.OUT_VALID, rf.OUT_ADDR, RC - 1); end
      ABORT = 1'b1;
      @(posedge CLK); #1; ABORT = 1'b0;
      @(negedge CLK); #1;
      checks++; if (DONE !== 1'b0 || BUSY !== 1'b0) begin failures++;
         $display("FAIL abortfin_state done=%b busy=%b exp=0/0", DONE, BUSY); end
      repeat (3) @(negedge CLK);
      checks++; if (done_count !== 0) begin failures++; $display("FAIL abortfin_no_done got=%0d exp=0", done_count); end
   endtask

   task automatic test_async_reset();
      int n;
      ready_mode = 0;
      @(negedge CLK); #1; START = 1'b1;
      @(posedge CLK); #1; START = 1'b0;
      n = 0;
      while (n < 200 && !(rf.OUT_VALID && rf.OUT_ADDR == AW'(9))) begin @(negedge CLK); #1; n++; end
      checks++; if (n >= 200) begin failures++; $display("FAIL rst_reach_addr9 got=timeout exp=addr9"); end
      #1; RST_N = 1'b0;
      #1;
      checks++; if (BUSY !== 1'b0 || rf.OUT_VALID !== 1'b0 || rf.OUT_DATA !== '0 || rf.OUT_ADDR !== '0 ||
                    rf.A1 !== '0 || rf.A2 !== '0 || DONE !== 1'b0) begin failures++;
         $display("FAIL rst_immediate busy=%b valid=%b data=%h addr=%0d a1=%0d a2=%0d exp=all0",
                  BUSY, rf.OUT_VALID, rf.OUT_DATA, rf.OUT_ADDR, rf.A1, rf.A2); end
      done_count = 0;
      @(negedge CLK); #1; RST_N = 1'b1;
      repeat (5) @(negedge CLK);
      #1;
      checks++; if (BUSY !== 1'b0 || rf.OUT_VALID !== 1'b0 || done_count !== 0) begin failures++;
         $display("FAIL rst_idle_hold busy=%b valid=%b dones=%0d exp=0/0/0", BUSY, rf.OUT_VALID, done_count); end
   endtask

   initial begin
      RST_N = 1'b0; START = 1'b0; ABORT = 1'b0;
      for (int i = 0; i < RC; i++) regs[i] = '0;
      test_reset();
      test_full_dump();
      test_backpressure();
      test_random_traffic();
      test_snapshot();
      test_abort();
      test_abort_final();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "timeout");
   end
endmodule
